inst_fetch_unit: RTL and testbench

- Producer end of the instruction interface feeding the decode/control stage.
- Holds the PC and issues word fetches to instruction memory over a request/response handshake.
- Presents each fetched instruction with its PC to decode over a valid/ready handshake.
- Accepts redirects (jump/branch targets) and a halt request (from the ebreak trap path).

---
 rtl/inst_fetch_unit_pkg.sv | 24 ++
 rtl/inst_fetch_pc_gen.sv | 35 +++
 rtl/inst_fetch_unit.sv | 169 ++++++++++++++++
 tb/tb_inst_fetch_unit.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/inst_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit: widths, reset PC, NOP encoding,
// FSM state encodings and next-PC select codes.
package inst_fetch_unit_pkg;

  localparam int          IFU_XLEN         = 32;
  localparam int          REG_BUS_W        = IFU_XLEN;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;
  localparam logic [31:0] NOP_INST         = 32'h0000_0013;

  typedef enum logic [2:0] {
    IFU_IDLE = 3'd0,
    IFU_REQ  = 3'd1,
    IFU_WAIT = 3'd2,
    IFU_HOLD = 3'd3,
    IFU_HALT = 3'd4
  } ifu_state_e;

  typedef enum logic [1:0] {
    PC_HOLD  = 2'd0,
    PC_INC   = 2'd1,
    PC_REDIR = 2'd2
  } pc_sel_e;

endpackage

// File: rtl/inst_fetch_pc_gen.sv
// Program counter register with next-PC selection: hold, sequential +4 (wrapping),
// or redirect target.
module inst_fetch_pc_gen
  import inst_fetch_unit_pkg::*;
#(
  parameter int              XLEN     = IFU_XLEN,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEFAULT)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  pc_sel_e         sel_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  output logic [XLEN-1:0] pc_o
);

  logic [XLEN-1:0] pc_d;
  logic [XLEN-1:0] pc_q;

  always_comb begin
    pc_d = pc_q;
    case (sel_i)
      PC_INC:   pc_d = pc_q + XLEN'(4);
      PC_REDIR: pc_d = redirect_pc_i;
      default:  pc_d = pc_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pc_q <= RESET_PC;
    else        pc_q <= pc_d;
  end

  assign pc_o = pc_q;

endmodule

// File: rtl/inst_fetch_unit.sv
// Instruction fetch unit: single-outstanding imem request/response, valid/ready to decode,
// redirect and sticky halt. Optional misaligned-PC trap under macro IFU_ALIGN_CHECK_EN.
module inst_fetch_unit
  import inst_fetch_unit_pkg::*;
#(
  parameter int              XLEN     = IFU_XLEN,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEFAULT)
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  output logic [XLEN-1:0] inst,
  output logic [XLEN-1:0] inst_pc,
  output logic            inst_valid,
  input  logic            inst_ready,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            halt,
  output logic            halted,
  output logic            fetch_fault
);

  ifu_state_e      state_q, state_d;
  logic            kill_q, kill_d;
  logic            hpend_q, hpend_d;
  logic [XLEN-1:0] inst_q, inst_d;
  logic [XLEN-1:0] inst_pc_q, inst_pc_d;
  logic            inst_valid_q, inst_valid_d;
  pc_sel_e         pc_sel;
  logic [XLEN-1:0] pc;
  logic            misalign;

  inst_fetch_pc_gen #(
    .XLEN     (XLEN),
    .RESET_PC (RESET_PC)
  ) u_pc_gen (
    .clk           (clk),
    .rst_n         (rst_n),
    .sel_i         (pc_sel),
    .redirect_pc_i (redirect_pc),
    .pc_o          (pc)
  );

`ifdef IFU_ALIGN_CHECK_EN
  logic fault_q;
  assign misalign = |pc[1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                  fault_q <= 1'b0;
    else if ((state_q == IFU_REQ) && misalign)   fault_q <= 1'b1;
    else                                         fault_q <= fault_q;
  end

  assign fetch_fault = fault_q;
`else
  assign misalign    = 1'b0;
  assign fetch_fault = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IFU_IDLE;
      kill_q       <= 1'b0;
      hpend_q      <= 1'b0;
      inst_q       <= XLEN'(NOP_INST);
      inst_pc_q    <= RESET_PC;
      inst_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      kill_q       <= kill_d;
      hpend_q      <= hpend_d;
      inst_q       <= inst_d;
      inst_pc_q    <= inst_pc_d;
      inst_valid_q <= inst_valid_d;
    end
  end

  // Priority in every state: halt, then redirect, then normal flow.
  always_comb begin
    state_d      = state_q;
    kill_d       = kill_q;
    hpend_d      = hpend_q;
    inst_d       = inst_q;
    inst_pc_d    = inst_pc_q;
    inst_valid_d = inst_valid_q;
    pc_sel       = PC_HOLD;
    case (state_q)
      IFU_IDLE: state_d = halt ? IFU_HALT : IFU_REQ;
      IFU_REQ: begin
        if (misalign) begin
          state_d = IFU_HALT;
        end else if (imem_req_ready) begin
          state_d = IFU_WAIT;
          if (halt) begin
            hpend_d = 1'b1;
          end else if (redirect_valid) begin
            kill_d = 1'b1;
            pc_sel = PC_REDIR;
          end else begin
            kill_d = 1'b0;
          end
        end else if (halt) begin
          state_d = IFU_HALT;
        end else if (redirect_valid) begin
          pc_sel = PC_REDIR;
        end else begin
          pc_sel = PC_HOLD;
        end
      end
      IFU_WAIT: begin
        if (imem_rsp_valid) begin
          if (halt || hpend_q) begin
            state_d = IFU_HALT;
            kill_d  = 1'b0;
          end else if (kill_q || redirect_valid) begin
            kill_d  = 1'b0;
            state_d = IFU_REQ;
            pc_sel  = redirect_valid ? PC_REDIR : PC_HOLD;
          end else begin
            inst_d       = imem_rsp_data;
            inst_pc_d    = pc;
            inst_valid_d = 1'b1;
            state_d      = IFU_HOLD;
          end
        end else if (halt || hpend_q) begin
          hpend_d = 1'b1;
        end else if (redirect_valid) begin
          kill_d = 1'b1;
          pc_sel = PC_REDIR;
        end else begin
          kill_d = kill_q;
        end
      end
      IFU_HOLD: begin
        if (halt) begin
          inst_valid_d = 1'b0;
          state_d      = IFU_HALT;
        end else if (redirect_valid) begin
          inst_valid_d = 1'b0;
          pc_sel       = PC_REDIR;
          state_d      = IFU_REQ;
        end else if (inst_ready) begin
          inst_valid_d = 1'b0;
          pc_sel       = PC_INC;
          state_d      = IFU_REQ;
        end else begin
          inst_valid_d = 1'b1;
        end
      end
      IFU_HALT: state_d = IFU_HALT;
      default:  state_d = IFU_IDLE;
    endcase
  end

  always_comb begin
    imem_req_valid = (state_q == IFU_REQ) && !misalign;
    halted         = (state_q == IFU_HALT);
  end

  assign imem_req_addr = pc;
  assign inst          = inst_q;
  assign inst_pc       = inst_pc_q;
  assign inst_valid    = inst_valid_q;

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Self-checking bench for inst_fetch_unit: transaction-level PC model plus directed scenarios.
// Exercises the misaligned-PC trap only when IFU_ALIGN_CHECK_EN is defined.
module tb_inst_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic [31:0] inst, inst_pc;
  logic        inst_valid, inst_ready;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        halt, halted, fetch_fault;

  int n_chk  = 0;
  int n_fail = 0;

  inst_fetch_unit dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .inst(inst), .inst_pc(inst_pc), .inst_valid(inst_valid), .inst_ready(inst_ready),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .halt(halt), .halted(halted), .fetch_fault(fetch_fault)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %h expected %h", nm, act, exp);
    end
  endtask

  // Memory model and architectural model share this state.
  int          mem_lat = 1;
  int          cyc = 0;
  int          out_cnt = 0;
  int          q_due[$];
  logic [31:0] q_addr[$];
  logic        nxt_v = 1'b0;
  logic [31:0] nxt_d = 32'h0;

  logic        m_idle = 1'b1;
  logic [31:0] m_exp_pc = 32'h8000_0000;
  logic        m_halt_req = 1'b0;
  logic        m_exp_halted = 1'b0;
  logic        m_hold_prev = 1'b0;
  logic [31:0] m_prev_inst, m_prev_pc;

  always @(posedge clk) begin
    #1;
    imem_rsp_valid = nxt_v;
    imem_rsp_data  = nxt_d;
  end

  // Compare process: checks outputs each cycle, then advances memory and PC model.
  always @(negedge clk) begin
    logic is_idle, acc, halt_eff;
    if (!rst_n) begin
      chk("rst_req_valid", {31'd0, imem_req_valid}, 32'd0);
      chk("rst_req_addr", imem_req_addr, 32'h8000_0000);
      chk("rst_inst", inst, 32'h0000_0013);
      chk("rst_inst_pc", inst_pc, 32'h8000_0000);
      chk("rst_inst_valid", {31'd0, inst_valid}, 32'd0);
      chk("rst_halted", {31'd0, halted}, 32'd0);
      chk("rst_fault", {31'd0, fetch_fault}, 32'd0);
      m_idle = 1'b1; m_exp_pc = 32'h8000_0000; m_halt_req = 1'b0;
      m_exp_halted = 1'b0; m_hold_prev = 1'b0;
      q_due.delete(); q_addr.delete(); out_cnt = 0; nxt_v = 1'b0;
    end else begin
      is_idle = m_idle;
      m_idle  = 1'b0;
      acc     = imem_req_valid && imem_req_ready;
      if (is_idle) chk("idle_no_req", {31'd0, imem_req_valid}, 32'd0);
      if (imem_req_valid) begin
        chk("req_addr", imem_req_addr, m_exp_pc);
        chk("req_single_outstanding", out_cnt, 0);
        chk("req_while_inst_valid", {31'd0, inst_valid}, 32'd0);
      end
      if (inst_valid) begin
        chk("inst_pc", inst_pc, m_exp_pc);
        chk("inst_data", inst, memf(inst_pc));
      end
      if (m_hold_prev) begin
        chk("hold_valid", {31'd0, inst_valid}, 32'd1);
        chk("hold_inst", inst, m_prev_inst);
        chk("hold_pc", inst_pc, m_prev_pc);
      end
      if (m_halt_req || halted) begin
        chk("halt_no_req", {31'd0, imem_req_valid}, 32'd0);
        chk("halt_no_inst", {31'd0, inst_valid}, 32'd0);
      end
      if (m_exp_halted) chk("halted_expected", {31'd0, halted}, 32'd1);
`ifdef IFU_ALIGN_CHECK_EN
      if (!m_halt_req && !fetch_fault) chk("halted_spurious", {31'd0, halted}, 32'd0);
      if (fetch_fault) chk("fault_implies_halted", {31'd0, halted}, 32'd1);
      if (imem_req_valid) chk("req_aligned", {30'd0, imem_req_addr[1:0]}, 32'd0);
`else
      if (!m_halt_req) chk("halted_spurious", {31'd0, halted}, 32'd0);
      chk("fault_tied_zero", {31'd0, fetch_fault}, 32'd0);
`endif
      halt_eff = m_halt_req || halt;
      if (!halt_eff && !is_idle) begin
        if (redirect_valid)               m_exp_pc = redirect_pc;
        else if (inst_valid && inst_ready) m_exp_pc = m_exp_pc + 32'd4;
      end
      m_hold_prev = inst_valid && !inst_ready && !redirect_valid && !halt_eff;
      m_prev_inst = inst;
      m_prev_pc   = inst_pc;
      if (imem_rsp_valid) out_cnt--;
      if (acc) begin
        q_due.push_back(cyc + mem_lat);
        q_addr.push_back(imem_req_addr);
        out_cnt++;
      end
      if (halt_eff && out_cnt == 0) m_exp_halted = 1'b1;
      m_halt_req = halt_eff;
      nxt_v = 1'b0;
      if (q_due.size() > 0 && q_due[0] == cyc + 1) begin
        nxt_v = 1'b1;
        nxt_d = memf(q_addr[0]);
        void'(q_due.pop_front());
        void'(q_addr.pop_front());
      end
    end
    cyc++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic sel_sig(input int which);
    case (which)
      0:       return imem_req_valid;
      1:       return inst_valid;
      default: return halted;
    endcase
  endfunction

  task automatic wait_for(input int which, input string nm);
    int n = 0;
    while (!sel_sig(which) && n < 30) begin
      tick();
      n++;
    end
    chk(nm, {31'd0, sel_sig(which)}, 32'd1);
  endtask

  task automatic pulse_redirect(input logic [31:0] tgt);
    redirect_valid = 1'b1;
    redirect_pc    = tgt;
    tick();
    redirect_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: actual timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    rst_n = 1'b0; imem_req_ready = 1'b1; inst_ready = 1'b0;
    redirect_valid = 1'b0; redirect_pc = 32'h0; halt = 1'b0;
    imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0;
    repeat (3) tick();
    rst_n = 1'b1;

    // First fetch and hold with decode stalled
    wait_for(0, "first_req_wait");
    chk("first_req_addr", imem_req_addr, 32'h8000_0000);
    wait_for(1, "first_inst_wait");
    chk("first_inst_pc", inst_pc, 32'h8000_0000);
    chk("first_inst", inst, 32'h40DE_0000);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_valid", {31'd0, inst_valid}, 32'd1);
      chk("stall_pc", inst_pc, 32'h8000_0000);
      chk("stall_no_req", {31'd0, imem_req_valid}, 32'd0);
    end
    inst_ready = 1'b1; tick(); inst_ready = 1'b0;
    chk("second_req_addr", imem_req_addr, 32'h8000_0004);
    chk("second_req_valid", {31'd0, imem_req_valid}, 32'd1);

    // Redirect in WAIT, response arriving the same cycle
    tick();
    pulse_redirect(32'h8000_0100);
    wait_for(0, "redir_req_wait");
    chk("redir_req_addr", imem_req_addr, 32'h8000_0100);
    wait_for(1, "redir_inst_wait");
    chk("redir_inst_pc", inst_pc, 32'h8000_0100);

    // Redirect in WAIT with 3-cycle memory: late response killed
    mem_lat = 3;
    inst_ready = 1'b1; tick(); inst_ready = 1'b0;
    tick(); tick();
    pulse_redirect(32'h8000_0200);
    wait_for(1, "kill_inst_wait");
    chk("kill_inst_pc", inst_pc, 32'h8000_0200);
    chk("kill_inst", inst, 32'h40DE_0200);

    // REQ back-pressured: stable address, then redirect while not accepted
    imem_req_ready = 1'b0;
    inst_ready = 1'b1; tick(); inst_ready = 1'b0;
    chk("bp_req_addr0", imem_req_addr, 32'h8000_0204);
    tick();
    chk("bp_req_addr1", imem_req_addr, 32'h8000_0204);
    chk("bp_req_valid", {31'd0, imem_req_valid}, 32'd1);
    pulse_redirect(32'h8000_0300);
    chk("bp_redir_addr", imem_req_addr, 32'h8000_0300);
    // Redirect in the same cycle the request is accepted
    imem_req_ready = 1'b1;
    pulse_redirect(32'h8000_0400);
    wait_for(1, "accred_inst_wait");
    chk("accred_inst_pc", inst_pc, 32'h8000_0400);
    mem_lat = 1;

    // Redirect in HOLD to the top of the address space, then wrap
    pulse_redirect(32'hFFFF_FFFC);
    wait_for(1, "top_inst_wait");
    chk("top_inst_pc", inst_pc, 32'hFFFF_FFFC);
    inst_ready = 1'b1; tick(); inst_ready = 1'b0;
    chk("wrap_req_addr", imem_req_addr, 32'h0000_0000);
    wait_for(1, "wrap_inst_wait");
    chk("wrap_inst_pc", inst_pc, 32'h0000_0000);
    chk("wrap_inst", inst, 32'hC0DE_0000);

    // Throughput: one instruction every 3 cycles
    inst_ready = 1'b1;
    cnt = 0;
    for (int i = 0; i < 12; i++) begin
      if (inst_valid) cnt++;
      tick();
    end
    inst_ready = 1'b0;
    chk("throughput_count", cnt, 4);
    chk("throughput_pc", inst_pc, 32'h0000_0010);

    // Halt together with inst_ready in HOLD
    inst_ready = 1'b1; halt = 1'b1; tick(); halt = 1'b0; inst_ready = 1'b0;
    chk("halt_hold_halted", {31'd0, halted}, 32'd1);
    chk("halt_hold_no_inst", {31'd0, inst_valid}, 32'd0);
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      if (imem_req_valid) cnt++;
      tick();
    end
    chk("halt_no_req_20", cnt, 0);
    chk("halt_sticky", {31'd0, halted}, 32'd1);

    // Reset mid-transaction, then halt while a response is outstanding
    rst_n = 1'b0; mem_lat = 3; tick(); tick(); rst_n = 1'b1;
    wait_for(0, "r2_req_wait");
    chk("r2_req_addr", imem_req_addr, 32'h8000_0000);
    tick();
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    chk("r3_halted", {31'd0, halted}, 32'd0);
    wait_for(0, "r3_req_wait");
    chk("r3_req_addr", imem_req_addr, 32'h8000_0000);
    tick();
    halt = 1'b1; tick(); halt = 1'b0;
    chk("drain_not_halted", {31'd0, halted}, 32'd0);
    wait_for(2, "drain_halted_wait");
    chk("drain_no_inst", {31'd0, inst_valid}, 32'd0);

`ifdef IFU_ALIGN_CHECK_EN
    // Misaligned redirect trapped at the next REQ
    rst_n = 1'b0; mem_lat = 1; tick(); tick(); rst_n = 1'b1;
    wait_for(1, "al_inst_wait");
    pulse_redirect(32'h8000_0002);
    chk("al_no_req", {31'd0, imem_req_valid}, 32'd0);
    tick();
    chk("al_halted", {31'd0, halted}, 32'd1);
    chk("al_fault", {31'd0, fetch_fault}, 32'd1);
    repeat (3) tick();
    chk("al_fault_sticky", {31'd0, fetch_fault}, 32'd1);
`endif

    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
